// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: issues sequential word reads, buffers variable-latency
// responses, and presents the head instruction to decode with stall and redirect support.
module rv_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0]   buf_ir_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q [BUF_DEPTH];

  logic          pop, resp, drop, push_we;
  logic [CW:0]   level;

  assign f_valid_o = (occ_q != '0);
  assign f_ir_o    = f_valid_o ? buf_ir_q[head_q] : '0;
  assign f_pc_o    = f_valid_o ? buf_pc_q[head_q] : '0;
  assign im_addr_o = fetch_pc_q;

  assign pop     = f_valid_o && !f_stall_i;
  assign resp    = im_valid_i && (out_q != '0);
  assign drop    = resp && (discard_q != '0);
  assign push_we = resp && !drop && !x_bra_i;

  // Buffered plus in-flight words, less the one decode takes this cycle, bounds new requests.
  assign level   = {1'b0, occ_q} + {1'b0, out_q} - (CW+1)'(pop);
  assign im_rd_o = rst_n_i && !x_bra_i && (level < (CW+1)'(BUF_DEPTH));

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    discard_d  = discard_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (x_bra_i) begin
      // Every request still in flight after this cycle predates the redirect and must be dropped.
      fetch_pc_d = {x_bra_target_i[31:2], 2'b00};
      resp_pc_d  = {x_bra_target_i[31:2], 2'b00};
      out_d      = out_q - CW'(resp);
      discard_d  = out_q - CW'(resp);
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (im_rd_o) fetch_pc_d = fetch_pc_q + 32'd4;
      out_d = out_q + CW'(im_rd_o) - CW'(resp);
      if (drop) discard_d = discard_q - CW'(1);
      if (push_we) begin
        tail_d    = tail_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + PW'(1);
      occ_d = occ_q + CW'(push_we) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      out_q      <= '0;
      discard_q  <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // NOTE: buffer storage has no reset; occupancy alone decides what is valid, and outputs are masked when empty.
  always_ff @(posedge clk_i) begin
    if (push_we) begin
      buf_ir_q[tail_q] <= im_data_i;
      buf_pc_q[tail_q] <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit: in-order variable-latency memory model plus an
// instruction-stream reference (decode must see target, target+4, ... with matching data).
module tb_rv_fetch_unit;

  localparam logic [31:0] RV        = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i = '0;
  logic        im_valid_i = 1'b0;
  logic        f_stall_i = 1'b0;
  logic        x_bra_i = 1'b0;
  logic [31:0] x_bra_target_i = '0;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  rv_fetch_unit #(.RESET_VECTOR(RV), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .im_addr_o(im_addr_o), .im_rd_o(im_rd_o),
    .im_data_i(im_data_i), .im_valid_i(im_valid_i),
    .f_stall_i(f_stall_i), .x_bra_i(x_bra_i), .x_bra_target_i(x_bra_target_i),
    .f_ir_o(f_ir_o), .f_pc_o(f_pc_o), .f_valid_o(f_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, last_due = -1;
  int          lat_min = 1, lat_max = 1;
  logic        drv_stall = 0, drv_bra = 0, bra_on_resp = 0;
  logic [31:0] drv_tgt = '0;
  logic [31:0] exp_fetch = RV, exp_pop = RV;
  logic        obs_rd, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_ir;

  // Memory contents: odd multiplier makes every word address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic model_reset();
    mq.delete();
    cyc = 0;
    last_due = -1;
    exp_fetch = RV;
    exp_pop = RV;
  endtask

  // One clock cycle; called just after a rising edge, returns just after the next one.
  task automatic tick();
    int lat, due;
    f_stall_i = drv_stall;
    x_bra_i = drv_bra;
    x_bra_target_i = drv_tgt;
    im_valid_i = 1'b0;
    im_data_i = '0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      im_valid_i = 1'b1;
      im_data_i = mem_word(mq[0].addr);
    end
    if (bra_on_resp && im_valid_i && f_valid_o) begin
      x_bra_i = 1'b1;
      bra_on_resp = 1'b0;
    end
    @(negedge clk_i);
    obs_rd = im_rd_o; obs_addr = im_addr_o; obs_valid = f_valid_o; obs_pc = f_pc_o; obs_ir = f_ir_o;
    if (im_valid_i) void'(mq.pop_front());
    if (x_bra_i) begin
      n_cmp++;
      if (im_rd_o !== 1'b0) begin
        n_err++; $display("FAIL rd_in_redirect: cyc %0d im_rd_o=%b want 0", cyc, im_rd_o);
      end
    end else if (im_rd_o) begin
      n_cmp++;
      if (im_addr_o !== exp_fetch) begin
        n_err++; $display("FAIL im_addr: cyc %0d got %h want %h", cyc, im_addr_o, exp_fetch);
      end
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{im_addr_o, due});
      exp_fetch = exp_fetch + 32'd4;
    end
    n_cmp++;
    if (f_valid_o) begin
      if (f_pc_o !== exp_pop || f_ir_o !== mem_word(exp_pop)) begin
        n_err++; $display("FAIL head: cyc %0d pc/ir %h/%h want %h/%h", cyc, f_pc_o, f_ir_o, exp_pop, mem_word(exp_pop));
      end
    end else if (f_pc_o !== 32'h0 || f_ir_o !== 32'h0) begin
      n_err++; $display("FAIL empty_head: cyc %0d pc/ir %h/%h want 0/0", cyc, f_pc_o, f_ir_o);
    end
    n_cmp++;
    if (mq.size() > BUF_DEPTH) begin
      n_err++; $display("FAIL outstanding: cyc %0d got %0d want <= %0d", cyc, mq.size(), BUF_DEPTH);
    end
    if (x_bra_i) begin
      exp_fetch = {x_bra_target_i[31:2], 2'b00};
      exp_pop = exp_fetch;
    end else if (f_valid_o && !f_stall_i) begin
      exp_pop = exp_pop + 32'd4;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    drv_bra = 1'b1; drv_tgt = tgt;
    tick();
    drv_bra = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #1;
    n_cmp += 5;
    if (im_rd_o !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b want 0", im_rd_o); end
    if (f_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", f_valid_o); end
    if (im_addr_o !== RV) begin n_err++; $display("FAIL rst_addr: got %h want %h", im_addr_o, RV); end
    if (f_ir_o !== 32'h0) begin n_err++; $display("FAIL rst_ir: got %h want 0", f_ir_o); end
    if (f_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", f_pc_o); end
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  // 1-cycle memory, no stall: a request every cycle, decode valid from cycle 2 on.
  task automatic test_stream();
    lat_min = 1; lat_max = 1; drv_stall = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp += 2;
      if (obs_rd !== 1'b1) begin n_err++; $display("FAIL stream_rd: k %0d got %b want 1", k, obs_rd); end
      if (obs_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid: k %0d got %b want %b", k, obs_valid, k >= 2); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    logic        resumed;
    lat_min = 1; lat_max = 1;
    repeat (3) tick();
    drv_stall = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) held_pc = obs_pc;
      if (k >= 1) begin
        n_cmp += 3;
        if (obs_rd !== 1'b0) begin n_err++; $display("FAIL stall_rd: k %0d got %b want 0", k, obs_rd); end
        if (obs_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: k %0d got %b want 1", k, obs_valid); end
        if (obs_pc !== held_pc) begin n_err++; $display("FAIL stall_hold: k %0d got %h want %h", k, obs_pc, held_pc); end
      end
    end
    drv_stall = 0;
    resumed = 0;
    for (int k = 0; k < 4 && !resumed; k++) begin
      tick();
      if (obs_rd) resumed = 1;
    end
    n_cmp++;
    if (!resumed) begin n_err++; $display("FAIL stall_resume: got no request want one within 4 cycles"); end
    repeat (4) tick();
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] want_pc);
    logic seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (obs_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || obs_pc !== want_pc) begin
      n_err++; $display("FAIL %s: valid %b pc %h want 1 %h", name, seen, obs_pc, want_pc);
    end
  endtask

  task automatic fill_outstanding(input string name);
    for (int k = 0; k < 10 && mq.size() < 2; k++) tick();
    n_cmp++;
    if (mq.size() != 2) begin n_err++; $display("FAIL %s_setup: outstanding %0d want 2", name, mq.size()); end
  endtask

  task automatic test_redirect_stale();
    lat_min = 3; lat_max = 3; drv_stall = 0;
    fill_outstanding("stale");
    redirect(32'h0000_0100);
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid: got %b want 0", obs_valid); end
    wait_first_valid("stale_first", 32'h0000_0100);
    repeat (6) tick();
  endtask

  task automatic test_redirect_full();
    lat_min = 3; lat_max = 3;
    redirect(32'h0000_0400);
    drv_stall = 1; drv_tgt = 32'h0000_0200; bra_on_resp = 1;
    for (int k = 0; k < 20 && bra_on_resp; k++) tick();
    n_cmp++;
    if (bra_on_resp) begin
      n_err++; bra_on_resp = 0; $display("FAIL full_setup: got no response while valid want one");
    end
    tick();
    n_cmp += 3;
    if (obs_valid !== 1'b0) begin n_err++; $display("FAIL full_flush: got %b want 0", obs_valid); end
    if (obs_rd !== 1'b1) begin n_err++; $display("FAIL full_restart_rd: got %b want 1", obs_rd); end
    if (obs_addr !== 32'h0000_0200) begin n_err++; $display("FAIL full_restart_addr: got %h want 200", obs_addr); end
    drv_stall = 0;
    wait_first_valid("full_first", 32'h0000_0200);
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    lat_min = 3; lat_max = 3; drv_stall = 0;
    fill_outstanding("b2b");
    redirect(32'h0000_0800);
    redirect(32'h0000_0A00);
    wait_first_valid("b2b_first", 32'h0000_0A00);
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    lat_min = 3; lat_max = 3; drv_stall = 0;
    fill_outstanding("rstmid");
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp += 3;
    if (f_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", f_valid_o); end
    if (im_rd_o !== 1'b0) begin n_err++; $display("FAIL rstmid_rd: got %b want 0", im_rd_o); end
    if (im_addr_o !== RV) begin n_err++; $display("FAIL rstmid_addr: got %h want %h", im_addr_o, RV); end
    im_valid_i = 1'b0; x_bra_i = 1'b0; f_stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
    tick();
    n_cmp++;
    if (obs_rd !== 1'b1 || obs_addr !== RV) begin
      n_err++; $display("FAIL rstmid_first: rd %b addr %h want 1 %h", obs_rd, obs_addr, RV);
    end
    wait_first_valid("rstmid_head", RV);
    repeat (4) tick();
  endtask

  task automatic test_align_wrap();
    logic seen_top, seen_wrap;
    lat_min = 1; lat_max = 2; drv_stall = 0;
    redirect(32'h0000_0103);
    tick();
    n_cmp++;
    if (obs_rd !== 1'b1 || obs_addr !== 32'h0000_0100) begin
      n_err++; $display("FAIL align_addr: rd %b addr %h want 1 00000100", obs_rd, obs_addr);
    end
    wait_first_valid("align_pc", 32'h0000_0100);
    redirect(32'hFFFF_FFF4);
    seen_top = 0; seen_wrap = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (obs_rd && obs_addr == 32'hFFFF_FFFC) seen_top = 1;
      if (obs_rd && seen_top && obs_addr == 32'h0) seen_wrap = 1;
    end
    n_cmp++;
    if (!seen_wrap) begin n_err++; $display("FAIL wrap: top %b wrap %b want 1 1", seen_top, seen_wrap); end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 800; k++) begin
      drv_stall = ($urandom_range(99, 0) < 30);
      drv_bra = ($urandom_range(99, 0) < 3);
      drv_tgt = $urandom();
      tick();
    end
    drv_stall = 0; drv_bra = 0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_full();
    test_back_to_back();
    test_reset_mid();
    test_align_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
